// File: rtl/rv64_int_exec.sv
// Single-issue RV64I integer execute unit: combinational decode, 32x64 register
// file and ALU, with the result presented on registered outputs one cycle later.
module rv64_int_exec #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  input  logic [31:0]              instr,
  input  logic [XLEN-1:0]          pc,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_result,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic                     out_illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data
);

  localparam int AW  = $clog2(NREGS);
  localparam int SHW = $clog2(XLEN);

  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcOpImm   = 7'b0010011;
  localparam logic [6:0] OpcOp32    = 7'b0111011;
  localparam logic [6:0] OpcOpImm32 = 7'b0011011;
  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;

  logic [XLEN-1:0] regs_q [NREGS];

  logic [6:0]      opcode;
  logic [AW-1:0]   rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] immI, immU;
  logic [XLEN-1:0] rs1Val, rs2Val;

  logic [XLEN-1:0] result_d;
  logic            illegal_d;
  logic [31:0]     word;

  logic            out_valid_q;
  logic [XLEN-1:0] out_result_q;
  logic [AW-1:0]   out_rd_q;
  logic            out_illegal_q;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign immI   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign immU   = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};

  // x0 is hardwired to zero on every read port, including debug.
  assign rs1Val   = (rs1 == '0) ? '0 : regs_q[rs1];
  assign rs2Val   = (rs2 == '0) ? '0 : regs_q[rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    word      = '0;
    unique case (opcode)
      OpcOp: begin
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000: result_d = rs1Val + rs2Val;
            3'b001: result_d = rs1Val << rs2Val[SHW-1:0];
            3'b010: result_d = {{(XLEN-1){1'b0}}, $signed(rs1Val) < $signed(rs2Val)};
            3'b011: result_d = {{(XLEN-1){1'b0}}, rs1Val < rs2Val};
            3'b100: result_d = rs1Val ^ rs2Val;
            3'b101: result_d = rs1Val >> rs2Val[SHW-1:0];
            3'b110: result_d = rs1Val | rs2Val;
            default: result_d = rs1Val & rs2Val;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          result_d = rs1Val - rs2Val;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          result_d = $signed(rs1Val) >>> rs2Val[SHW-1:0];
        end else begin
          illegal_d = 1'b1;
        end
      end
      OpcOpImm: begin
        unique case (funct3)
          3'b000: result_d = rs1Val + immI;
          3'b010: result_d = {{(XLEN-1){1'b0}}, $signed(rs1Val) < $signed(immI)};
          3'b011: result_d = {{(XLEN-1){1'b0}}, rs1Val < immI};
          3'b100: result_d = rs1Val ^ immI;
          3'b110: result_d = rs1Val | immI;
          3'b111: result_d = rs1Val & immI;
          3'b001: begin
            if (instr[31:26] == 6'b000000) result_d = rs1Val << instr[25:20];
            else                           illegal_d = 1'b1;
          end
          default: begin
            if (instr[31:26] == 6'b000000)      result_d = rs1Val >> instr[25:20];
            else if (instr[31:26] == 6'b010000) result_d = $signed(rs1Val) >>> instr[25:20];
            else                                illegal_d = 1'b1;
          end
        endcase
      end
      OpcOp32: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b000)      word = rs1Val[31:0] + rs2Val[31:0];
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) word = rs1Val[31:0] - rs2Val[31:0];
        else if (funct7 == 7'b0000000 && funct3 == 3'b001) word = rs1Val[31:0] << rs2Val[4:0];
        else if (funct7 == 7'b0000000 && funct3 == 3'b101) word = rs1Val[31:0] >> rs2Val[4:0];
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) word = $signed(rs1Val[31:0]) >>> rs2Val[4:0];
        else illegal_d = 1'b1;
        result_d = sext32(word);
      end
      OpcOpImm32: begin
        if (funct3 == 3'b000)                              word = rs1Val[31:0] + immI[31:0];
        else if (funct7 == 7'b0000000 && funct3 == 3'b001) word = rs1Val[31:0] << instr[24:20];
        else if (funct7 == 7'b0000000 && funct3 == 3'b101) word = rs1Val[31:0] >> instr[24:20];
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) word = $signed(rs1Val[31:0]) >>> instr[24:20];
        else illegal_d = 1'b1;
        result_d = sext32(word);
      end
      OpcLui:   result_d = immU;
      OpcAuipc: result_d = pc + immU;
      default:  illegal_d = 1'b1;
    endcase
    if (illegal_d) result_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (instr_valid && !illegal_d && rd != '0) begin
      regs_q[rd] <= result_d;
    end
  end

  // Result fields hold across idle cycles; only out_valid tracks every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q <= instr_valid;
      if (instr_valid) begin
        out_result_q  <= result_d;
        out_rd_q      <= rd;
        out_illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_rv64_int_exec.sv
// Scoreboard bench for rv64_int_exec: directed instructions push expected
// responses; a negedge monitor pops and compares whenever out_valid is high.
module tb_rv64_int_exec;

  logic        clk;
  logic        reset;
  logic        instrValid;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        outValid;
  logic [63:0] outResult;
  logic [4:0]  outRd;
  logic        outIllegal;
  logic [4:0]  dbgAddr;
  logic [63:0] dbgData;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        illegal;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  passed = 0;

  rv64_int_exec #(.XLEN(64), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instrValid),
    .instr      (instr),
    .pc         (pc),
    .out_valid  (outValid),
    .out_result (outResult),
    .out_rd     (outRd),
    .out_illegal(outIllegal),
    .dbg_addr   (dbgAddr),
    .dbg_data   (dbgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  task automatic checkReg(input logic [4:0] addr, input logic [63:0] exp);
    dbgAddr = addr;
    #1;
    checkOutput($sformatf("dbg x%0d", addr), dbgData, exp);
  endtask

  // Drives one instruction for exactly one rising edge and records what must come out.
  task automatic applyStimulus(input logic [31:0] ins, input logic [63:0] pcVal,
                               input logic [63:0] expRes, input logic [4:0] expRd,
                               input logic expIll);
    expT e;
    e.result = expRes;
    e.rd = expRd;
    e.illegal = expIll;
    expQ.push_back(e);
    instrValid = 1'b1;
    instr = ins;
    pc = pcVal;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && outValid) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected out_valid: got result 0x%h rd %0d, expected no output", outResult, outRd);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput("out_result", outResult, e.result);
        checkOutput("out_rd", {59'b0, outRd}, {59'b0, e.rd});
        checkOutput("out_illegal", {63'b0, outIllegal}, {63'b0, e.illegal});
      end
    end
  end

  initial begin
    reset = 1'b0;
    instrValid = 1'b0;
    instr = '0;
    pc = '0;
    dbgAddr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {63'b0, outValid}, 64'd0);
    checkOutput("reset out_result", outResult, 64'd0);
    for (int i = 0; i < 32; i++) checkReg(5'(i), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle out_valid", {63'b0, outValid}, 64'd0);

    applyStimulus(32'h00500093, 64'h0, 64'd5, 5'd1, 1'b0);
    applyStimulus(32'h00108133, 64'h0, 64'd10, 5'd2, 1'b0);
    checkReg(5'd2, 64'd10);
    checkReg(5'd1, 64'd5);

    applyStimulus(32'h800001B7, 64'h0, 64'hFFFFFFFF80000000, 5'd3, 1'b0);
    applyStimulus(32'h4041D213, 64'h0, 64'hFFFFFFFFF8000000, 5'd4, 1'b0);
    checkReg(5'd3, 64'hFFFFFFFF80000000);
    checkReg(5'd4, 64'hFFFFFFFFF8000000);

    applyStimulus(32'h80000337, 64'h0, 64'hFFFFFFFF80000000, 5'd6, 1'b0);
    applyStimulus(32'hFFF3039B, 64'h0, 64'h000000007FFFFFFF, 5'd7, 1'b0);
    checkReg(5'd7, 64'h000000007FFFFFFF);

    applyStimulus(32'h00700013, 64'h0, 64'd7, 5'd0, 1'b0);
    checkReg(5'd0, 64'd0);

    applyStimulus(32'h401102B3, 64'h0, 64'd5, 5'd5, 1'b0);
    applyStimulus(32'h0011A433, 64'h0, 64'd1, 5'd8, 1'b0);
    applyStimulus(32'h0011B4B3, 64'h0, 64'd0, 5'd9, 1'b0);
    applyStimulus(32'h0011D533, 64'h0, 64'h07FFFFFFFC000000, 5'd10, 1'b0);
    applyStimulus(32'h4020863B, 64'h0, 64'hFFFFFFFFFFFFFFFB, 5'd12, 1'b0);
    applyStimulus(32'h01F0969B, 64'h0, 64'hFFFFFFFF80000000, 5'd13, 1'b0);
    checkReg(5'd5, 64'd5);
    checkReg(5'd8, 64'd1);
    checkReg(5'd10, 64'h07FFFFFFFC000000);
    checkReg(5'd12, 64'hFFFFFFFFFFFFFFFB);
    checkReg(5'd13, 64'hFFFFFFFF80000000);

    applyStimulus(32'h00000003, 64'h0, 64'd0, 5'd0, 1'b1);
    applyStimulus(32'h00000000, 64'h0, 64'd0, 5'd0, 1'b1);
    applyStimulus(32'h03F0969B, 64'h0, 64'd0, 5'd13, 1'b1);
    applyStimulus(32'h4011C733, 64'h0, 64'd0, 5'd14, 1'b1);
    checkReg(5'd13, 64'hFFFFFFFF80000000);
    checkReg(5'd14, 64'd0);
    checkReg(5'd1, 64'd5);

    applyStimulus(32'h00001597, 64'h1000, 64'h2000, 5'd11, 1'b0);
    checkReg(5'd11, 64'h2000);
    repeat (2) @(posedge clk);
    #1;

    // Reset lands while an ADDI x15 is being presented; it must leave no trace.
    instrValid = 1'b1;
    instr = 32'h00900793;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async out_result", outResult, 64'd0);
    checkOutput("async out_rd", {59'b0, outRd}, 64'd0);
    checkOutput("async out_valid", {63'b0, outValid}, 64'd0);
    checkReg(5'd1, 64'd0);
    checkReg(5'd11, 64'd0);
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset out_valid", {63'b0, outValid}, 64'd0);
    checkReg(5'd15, 64'd0);

    applyStimulus(32'h00500093, 64'h0, 64'd5, 5'd1, 1'b0);
    checkReg(5'd1, 64'd5);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
